rdma_rc_qp_ctrl: RTL and testbench
==================================

Name: rdma_rc_qp_ctrl

Overview:
Per-QP RC state controller that sequences the PDU parser. It accepts modify-QP commands (RESET/INIT/RTR/RTS/ERROR) and drives qp_state, local_qpn and remote_qpn into the parser. It consumes the parser's per-PDU result strobe to track the expected receive PSN and count errors. It forces the QP into ERROR once the error count reaches a threshold.

Parameters:
QPN_WIDTH, 16, QPN field width
PSN_WIDTH, 24, PSN field width
ERR_CNT_WIDTH, 4, error counter width
ERR_THRESH, 4, error count that trips ERROR (1..2^ERR_CNT_WIDTH-1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  modify-QP request
cmd_ready  out  1  controller can accept a command
cmd_state  in  3  target state (000 RESET, 001 INIT, 010 RTR, 011 RTS, 111 ERROR)
cmd_local_qpn  in  QPN_WIDTH  local QPN, latched on INIT
cmd_remote_qpn  in  QPN_WIDTH  remote QPN, latched on INIT
cmd_init_psn  in  PSN_WIDTH  initial expected PSN, latched on RTR
cmd_reject  out  1  1-cycle pulse: accepted command was illegal or dropped
parse_done  in  1  parser result strobe
parse_opcode_err  in  1  parser opcode error, valid with parse_done
parse_qpn_err  in  1  parser QPN mismatch, valid with parse_done
parse_is_data  in  1  parser data-frame flag, valid with parse_done
parse_psn  in  PSN_WIDTH  parsed PSN, valid with parse_done
qp_state  out  3  current QP state, to parser
local_qpn  out  QPN_WIDTH  to parser
remote_qpn  out  QPN_WIDTH  to parser
expected_psn  out  PSN_WIDTH  next expected data PSN
psn_err  out  1  1-cycle pulse: PSN mismatch
err_cnt  out  ERR_CNT_WIDTH  saturating error count
qp_err_irq  out  1  1-cycle pulse on entry to ERROR by threshold

Behaviour:
- Reset (async, rst_n=0): qp_state=RESET, local_qpn/remote_qpn/expected_psn/err_cnt=0, cmd_ready=1, all pulses=0.
- All outputs are registered. Every effect appears on the clock edge after the triggering input.
- Handshake: a command is accepted when cmd_valid&&cmd_ready. cmd_ready is registered and drops for exactly one cycle after each accept, so there is at most one command per 2 cycles. cmd_* fields are sampled only at accept.
- Legal transitions:
  - any→RESET: clears QPNs, expected_psn and err_cnt.
  - RESET→INIT and INIT→INIT: latch both QPNs.
  - INIT→RTR: expected_psn<=cmd_init_psn.
  - RTR→RTS.
  - any→ERROR: no qp_err_irq on this path.
- Any other target, including unused encodings 100/101/110 and the same-state commands RTR→RTR and RTS→RTS: cmd_reject pulse, state and registers unchanged. In ERROR only RESET and ERROR are accepted without reject.
- Parse events: evaluated against the registered pre-edge qp_state. Ignored in ERROR.
  - RESET, INIT, RTR: parse_done with opcode_err|qpn_err → err_cnt+1.
  - RTS, data frame without errors: parse_psn==expected_psn → expected_psn+1, wrapping mod 2^PSN_WIDTH (FFFFFF→000000). Mismatch → psn_err pulse and err_cnt+1, expected_psn held.
  - RTS, control frame without errors: no effect.
- err_cnt saturates at all-ones.
- Threshold: when an increment makes err_cnt==ERR_THRESH, next qp_state=ERROR and qp_err_irq pulses.
- Same-edge priority: RESET command > threshold trip > other accepted command.
  - A non-RESET command accepted on the trip edge is dropped with cmd_reject.
  - A RESET command on the trip edge clears err_cnt and suppresses qp_err_irq.
- A parse event coincident with a command updates counters using the old state. Exception: a RESET command clears them.
- Asserting rst_n mid-operation returns all registers to reset values immediately. No pending command or pulse survives.

Test Plan:
1. Reset, then cmds INIT(1234/5678), RTR(psn=000010), RTS → qp_state 001/010/011, local_qpn=1234, remote_qpn=5678, expected_psn=000010, no cmd_reject; cmd_ready low 1 cycle after each accept.
2. From RESET cmd RTS → cmd_reject pulse, qp_state stays 000. From INIT cmd RTS → reject, stays 001.
3. In RTS with expected_psn=FFFFFF, clean data parse_psn=FFFFFF → expected_psn=000000. Then parse_psn=000005 → psn_err pulse, err_cnt=1, expected_psn=000000.
4. ERR_THRESH=4 in RTS, four parse_done with opcode_err → err_cnt=4, qp_state=111 and qp_err_irq pulse one cycle after the 4th. Further parse_done ignored; cmd RTS rejected; cmd RESET → qp_state 000, err_cnt 0.
5. err_cnt=3 in RTS, 4th error and RESET command on the same edge → qp_state=000, err_cnt=0, no qp_err_irq. Repeat with an RTR command instead → ERROR, qp_err_irq, cmd_reject.
6. rst_n pulsed low mid-RTS (err_cnt=2, expected_psn=000123) between edges → outputs reset asynchronously without waiting for clk.

Source files
------------

// File: rtl/rdma_rc_qp_ctrl.sv
// -----------------------------------------------------------------------------
// rdma_rc_qp_ctrl
//
// Per-QP Reliable Connection state controller that sequences the PDU parser.
// It accepts modify-QP commands (RESET/INIT/RTR/RTS/ERROR), drives qp_state
// and the local/remote QPNs into the parser, and consumes the parser's per-PDU
// result strobe to track the expected receive PSN and count errors. Once the
// error count reaches ERR_THRESH the QP is forced into ERROR.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   cmd_valid/ready    modify-QP handshake (ready drops 1 cycle after accept)
//   cmd_state          target state: 000 RESET, 001 INIT, 010 RTR, 011 RTS,
//                      111 ERROR
//   cmd_local_qpn      local QPN, latched on INIT
//   cmd_remote_qpn     remote QPN, latched on INIT
//   cmd_init_psn       initial expected PSN, latched on RTR
//   cmd_reject         1-cycle pulse: accepted command illegal or dropped
//   parse_*            parser result strobe and its qualifiers
//   qp_state           current QP state, to parser
//   local_qpn          local QPN, to parser
//   remote_qpn         remote QPN, to parser
//   expected_psn       next expected data PSN
//   psn_err            1-cycle pulse: PSN mismatch
//   err_cnt            saturating error count
//   qp_err_irq         1-cycle pulse on entry to ERROR by threshold
// -----------------------------------------------------------------------------
module rdma_rc_qp_ctrl #(
  parameter int QPN_WIDTH     = 16,
  parameter int PSN_WIDTH     = 24,
  parameter int ERR_CNT_WIDTH = 4,
  parameter int ERR_THRESH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_state,
  input  logic [QPN_WIDTH-1:0]     cmd_local_qpn,
  input  logic [QPN_WIDTH-1:0]     cmd_remote_qpn,
  input  logic [PSN_WIDTH-1:0]     cmd_init_psn,
  output logic                     cmd_reject,
  input  logic                     parse_done,
  input  logic                     parse_opcode_err,
  input  logic                     parse_qpn_err,
  input  logic                     parse_is_data,
  input  logic [PSN_WIDTH-1:0]     parse_psn,
  output logic [2:0]               qp_state,
  output logic [QPN_WIDTH-1:0]     local_qpn,
  output logic [QPN_WIDTH-1:0]     remote_qpn,
  output logic [PSN_WIDTH-1:0]     expected_psn,
  output logic                     psn_err,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic                     qp_err_irq
);

  typedef enum logic [2:0] {
    QP_RESET = 3'b000,
    QP_INIT  = 3'b001,
    QP_RTR   = 3'b010,
    QP_RTS   = 3'b011,
    QP_ERROR = 3'b111
  } qp_state_e;

  qp_state_e                state_reg,      state_next;
  logic [QPN_WIDTH-1:0]     local_qpn_reg,  local_qpn_next;
  logic [QPN_WIDTH-1:0]     remote_qpn_reg, remote_qpn_next;
  logic [PSN_WIDTH-1:0]     exp_psn_reg,    exp_psn_next;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_reg,    err_cnt_next;
  logic                     cmd_ready_reg,  cmd_ready_next;
  logic                     cmd_reject_reg, cmd_reject_next;
  logic                     psn_err_reg,    psn_err_next;
  logic                     irq_reg,        irq_next;

  logic                     accept;
  logic                     cmd_legal;
  logic                     err_inc;
  logic [ERR_CNT_WIDTH-1:0] err_sum;
  logic                     trip;

  assign accept = cmd_valid && cmd_ready_reg;

  // Legality of the requested transition from the current state. RESET and
  // ERROR are reachable from anywhere; same-state RTR/RTS and the unused
  // encodings fall to the default and are rejected.
  always_comb begin
    cmd_legal = 1'b0;
    case (cmd_state)
      QP_RESET: cmd_legal = 1'b1;
      QP_ERROR: cmd_legal = 1'b1;
      QP_INIT:  cmd_legal = (state_reg == QP_RESET) || (state_reg == QP_INIT);
      QP_RTR:   cmd_legal = (state_reg == QP_INIT);
      QP_RTS:   cmd_legal = (state_reg == QP_RTR);
      default:  cmd_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    local_qpn_next  = local_qpn_reg;
    remote_qpn_next = remote_qpn_reg;
    exp_psn_next    = exp_psn_reg;
    err_cnt_next    = err_cnt_reg;
    cmd_ready_next  = !accept;
    cmd_reject_next = 1'b0;
    psn_err_next    = 1'b0;
    irq_next        = 1'b0;
    err_inc         = 1'b0;

    // Parser results are judged against the pre-edge state, so a command
    // landing on the same edge never changes how the PDU is scored.
    if (parse_done && (state_reg != QP_ERROR)) begin
      if (parse_opcode_err || parse_qpn_err) begin
        err_inc = 1'b1;
      end else if ((state_reg == QP_RTS) && parse_is_data) begin
        if (parse_psn == exp_psn_reg) begin
          exp_psn_next = exp_psn_reg + PSN_WIDTH'(1);
        end else begin
          psn_err_next = 1'b1;
          err_inc      = 1'b1;
        end
      end
    end

    err_sum = (&err_cnt_reg) ? err_cnt_reg : err_cnt_reg + ERR_CNT_WIDTH'(1);
    trip    = err_inc && (err_sum == ERR_CNT_WIDTH'(ERR_THRESH));
    if (err_inc) begin
      err_cnt_next = err_sum;
    end

    // Priority: RESET command, then threshold trip, then any other command.
    if (accept && (cmd_state == QP_RESET)) begin
      state_next      = QP_RESET;
      local_qpn_next  = '0;
      remote_qpn_next = '0;
      exp_psn_next    = '0;
      err_cnt_next    = '0;
    end else if (trip) begin
      state_next      = QP_ERROR;
      irq_next        = 1'b1;
      cmd_reject_next = accept;
    end else if (accept) begin
      if (!cmd_legal) begin
        cmd_reject_next = 1'b1;
      end else begin
        case (cmd_state)
          QP_INIT: begin
            state_next      = QP_INIT;
            local_qpn_next  = cmd_local_qpn;
            remote_qpn_next = cmd_remote_qpn;
          end
          QP_RTR: begin
            state_next   = QP_RTR;
            exp_psn_next = cmd_init_psn;
          end
          QP_RTS:   state_next = QP_RTS;
          QP_ERROR: state_next = QP_ERROR;
          default:  state_next = state_reg;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= QP_RESET;
      local_qpn_reg  <= '0;
      remote_qpn_reg <= '0;
      exp_psn_reg    <= '0;
      err_cnt_reg    <= '0;
      cmd_ready_reg  <= 1'b1;
      cmd_reject_reg <= 1'b0;
      psn_err_reg    <= 1'b0;
      irq_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      local_qpn_reg  <= local_qpn_next;
      remote_qpn_reg <= remote_qpn_next;
      exp_psn_reg    <= exp_psn_next;
      err_cnt_reg    <= err_cnt_next;
      cmd_ready_reg  <= cmd_ready_next;
      cmd_reject_reg <= cmd_reject_next;
      psn_err_reg    <= psn_err_next;
      irq_reg        <= irq_next;
    end
  end

  assign qp_state     = state_reg;
  assign local_qpn    = local_qpn_reg;
  assign remote_qpn   = remote_qpn_reg;
  assign expected_psn = exp_psn_reg;
  assign err_cnt      = err_cnt_reg;
  assign cmd_ready    = cmd_ready_reg;
  assign cmd_reject   = cmd_reject_reg;
  assign psn_err      = psn_err_reg;
  assign qp_err_irq   = irq_reg;

endmodule

// File: tb/tb_rdma_rc_qp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rdma_rc_qp_ctrl
//
// Directed, table-driven bench for rdma_rc_qp_ctrl (default parameters,
// ERR_THRESH = 4). Each vector drives one cycle of inputs and compares every
// output one clock edge later against a hand-computed expectation. The
// same-edge command/threshold cases and the asynchronous reset are written
// out as explicit sequences.
// -----------------------------------------------------------------------------
module tb_rdma_rc_qp_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_state;
  logic [15:0] cmd_local_qpn;
  logic [15:0] cmd_remote_qpn;
  logic [23:0] cmd_init_psn;
  logic        cmd_reject;
  logic        parse_done;
  logic        parse_opcode_err;
  logic        parse_qpn_err;
  logic        parse_is_data;
  logic [23:0] parse_psn;
  logic [2:0]  qp_state;
  logic [15:0] local_qpn;
  logic [15:0] remote_qpn;
  logic [23:0] expected_psn;
  logic        psn_err;
  logic [3:0]  err_cnt;
  logic        qp_err_irq;

  rdma_rc_qp_ctrl #(
    .QPN_WIDTH(16), .PSN_WIDTH(24), .ERR_CNT_WIDTH(4), .ERR_THRESH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_state(cmd_state),
    .cmd_local_qpn(cmd_local_qpn), .cmd_remote_qpn(cmd_remote_qpn),
    .cmd_init_psn(cmd_init_psn), .cmd_reject(cmd_reject),
    .parse_done(parse_done), .parse_opcode_err(parse_opcode_err),
    .parse_qpn_err(parse_qpn_err), .parse_is_data(parse_is_data),
    .parse_psn(parse_psn),
    .qp_state(qp_state), .local_qpn(local_qpn), .remote_qpn(remote_qpn),
    .expected_psn(expected_psn), .psn_err(psn_err), .err_cnt(err_cnt),
    .qp_err_irq(qp_err_irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        cv;
    logic [2:0]  cs;
    logic [15:0] lq;
    logic [15:0] rq;
    logic [23:0] ip;
    logic        pd;
    logic        oe;
    logic        qe;
    logic        id;
    logic [23:0] pp;
  } stim_t;

  typedef struct packed {
    logic [2:0]  st;
    logic [15:0] lq;
    logic [15:0] rq;
    logic [23:0] psn;
    logic [3:0]  err;
    logic        rdy;
    logic        rej;
    logic        perr;
    logic        irq;
  } exp_t;

  typedef struct packed {
    stim_t s;
    exp_t  e;
  } vec_t;

  localparam logic [2:0] RST = 3'b000, INI = 3'b001, RTR = 3'b010,
                         RTS = 3'b011, ERR = 3'b111;

  int   nvec  = 0;
  int   nfail = 0;
  vec_t table_q[$];

  function automatic stim_t S_IDLE();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t S_CMD(input logic [2:0] cs, input logic [15:0] lq,
                                  input logic [15:0] rq, input logic [23:0] ip);
    stim_t s;
    s = '0;
    s.cv = 1'b1; s.cs = cs; s.lq = lq; s.rq = rq; s.ip = ip;
    return s;
  endfunction

  function automatic stim_t S_PAR(input logic oe, input logic qe,
                                  input logic id, input logic [23:0] pp);
    stim_t s;
    s = '0;
    s.pd = 1'b1; s.oe = oe; s.qe = qe; s.id = id; s.pp = pp;
    return s;
  endfunction

  function automatic exp_t E(input logic [2:0] st, input logic [15:0] lq,
                             input logic [15:0] rq, input logic [23:0] psn,
                             input logic [3:0] err, input logic rdy,
                             input logic rej, input logic perr, input logic irq);
    exp_t e;
    e.st = st; e.lq = lq; e.rq = rq; e.psn = psn; e.err = err;
    e.rdy = rdy; e.rej = rej; e.perr = perr; e.irq = irq;
    return e;
  endfunction

  function automatic void add(input stim_t s, input exp_t e);
    vec_t v;
    v.s = s;
    v.e = e;
    table_q.push_back(v);
  endfunction

  task automatic drive(input stim_t s);
    cmd_valid        = s.cv;
    cmd_state        = s.cs;
    cmd_local_qpn    = s.lq;
    cmd_remote_qpn   = s.rq;
    cmd_init_psn     = s.ip;
    parse_done       = s.pd;
    parse_opcode_err = s.oe;
    parse_qpn_err    = s.qe;
    parse_is_data    = s.id;
    parse_psn        = s.pp;
  endtask

  task automatic check(input exp_t e, input string name);
    exp_t a;
    a = {qp_state, local_qpn, remote_qpn, expected_psn, err_cnt,
         cmd_ready, cmd_reject, psn_err, qp_err_irq};
    nvec++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got st=%h lq=%h rq=%h psn=%h err=%h rdy=%b rej=%b perr=%b irq=%b, want st=%h lq=%h rq=%h psn=%h err=%h rdy=%b rej=%b perr=%b irq=%b",
               name, a.st, a.lq, a.rq, a.psn, a.err, a.rdy, a.rej, a.perr, a.irq,
               e.st, e.lq, e.rq, e.psn, e.err, e.rdy, e.rej, e.perr, e.irq);
    end else begin
      $display("ok   %s: st=%h lq=%h rq=%h psn=%h err=%h rdy=%b rej=%b perr=%b irq=%b",
               name, a.st, a.lq, a.rq, a.psn, a.err, a.rdy, a.rej, a.perr, a.irq);
    end
  endtask

  // Drive one cycle of stimulus, then check one step after the next edge.
  task automatic step(input stim_t s, input exp_t e, input string name);
    drive(s);
    @(posedge clk);
    #1;
    check(e, name);
  endtask

  // From RESET with err_cnt 0: INIT -> RTR -> RTS, checking each step.
  task automatic to_rts(input logic [15:0] lq, input logic [15:0] rq,
                        input logic [23:0] psn, input string tag);
    step(S_CMD(INI, lq, rq, 24'h0), E(INI, lq, rq, 24'h0, 4'd0, 0, 0, 0, 0), {tag, " init"});
    step(S_IDLE(),                  E(INI, lq, rq, 24'h0, 4'd0, 1, 0, 0, 0), {tag, " idle1"});
    step(S_CMD(RTR, 16'h0, 16'h0, psn), E(RTR, lq, rq, psn, 4'd0, 0, 0, 0, 0), {tag, " rtr"});
    step(S_IDLE(),                  E(RTR, lq, rq, psn, 4'd0, 1, 0, 0, 0), {tag, " idle2"});
    step(S_CMD(RTS, 16'h0, 16'h0, 24'h0), E(RTS, lq, rq, psn, 4'd0, 0, 0, 0, 0), {tag, " rts"});
    step(S_IDLE(),                  E(RTS, lq, rq, psn, 4'd0, 1, 0, 0, 0), {tag, " idle3"});
  endtask

  initial begin
    // ---------------- vector table ----------------
    // Bring-up, reject from INIT, ready-low ignore
    add(S_CMD(INI, 16'h1234, 16'h5678, 24'h0), E(INI, 16'h1234, 16'h5678, 24'h0, 4'd0, 0, 0, 0, 0));
    add(S_IDLE(),                              E(INI, 16'h1234, 16'h5678, 24'h0, 4'd0, 1, 0, 0, 0));
    add(S_CMD(RTS, 16'h0, 16'h0, 24'h0),       E(INI, 16'h1234, 16'h5678, 24'h0, 4'd0, 0, 1, 0, 0));
    add(S_IDLE(),                              E(INI, 16'h1234, 16'h5678, 24'h0, 4'd0, 1, 0, 0, 0));
    add(S_CMD(RTR, 16'h0, 16'h0, 24'h000010),  E(RTR, 16'h1234, 16'h5678, 24'h10, 4'd0, 0, 0, 0, 0));
    add(S_CMD(RST, 16'h0, 16'h0, 24'h0),       E(RTR, 16'h1234, 16'h5678, 24'h10, 4'd0, 1, 0, 0, 0));
    add(S_CMD(RTS, 16'h0, 16'h0, 24'h0),       E(RTS, 16'h1234, 16'h5678, 24'h10, 4'd0, 0, 0, 0, 0));
    add(S_IDLE(),                              E(RTS, 16'h1234, 16'h5678, 24'h10, 4'd0, 1, 0, 0, 0));
    // RTS parse traffic
    add(S_PAR(0, 0, 1, 24'h10),                E(RTS, 16'h1234, 16'h5678, 24'h11, 4'd0, 1, 0, 0, 0));
    add(S_PAR(0, 0, 1, 24'h11),                E(RTS, 16'h1234, 16'h5678, 24'h12, 4'd0, 1, 0, 0, 0));
    add(S_PAR(0, 0, 1, 24'h05),                E(RTS, 16'h1234, 16'h5678, 24'h12, 4'd1, 1, 0, 1, 0));
    add(S_PAR(0, 0, 0, 24'h99),                E(RTS, 16'h1234, 16'h5678, 24'h12, 4'd1, 1, 0, 0, 0));
    add(S_PAR(0, 1, 1, 24'h12),                E(RTS, 16'h1234, 16'h5678, 24'h12, 4'd2, 1, 0, 0, 0));
    add(S_CMD(RTR, 16'h0, 16'h0, 24'h0),       E(RTS, 16'h1234, 16'h5678, 24'h12, 4'd2, 0, 1, 0, 0));
    add(S_IDLE(),                              E(RTS, 16'h1234, 16'h5678, 24'h12, 4'd2, 1, 0, 0, 0));
    add(S_CMD(RST, 16'h0, 16'h0, 24'h0),       E(RST, 16'h0, 16'h0, 24'h0, 4'd0, 0, 0, 0, 0));
    add(S_IDLE(),                              E(RST, 16'h0, 16'h0, 24'h0, 4'd0, 1, 0, 0, 0));
    // Reject from RESET, errors counted in RESET, unused encoding, ERROR path
    add(S_CMD(RTS, 16'h0, 16'h0, 24'h0),       E(RST, 16'h0, 16'h0, 24'h0, 4'd0, 0, 1, 0, 0));
    add(S_IDLE(),                              E(RST, 16'h0, 16'h0, 24'h0, 4'd0, 1, 0, 0, 0));
    add(S_PAR(1, 0, 0, 24'h0),                 E(RST, 16'h0, 16'h0, 24'h0, 4'd1, 1, 0, 0, 0));
    add(S_CMD(3'b101, 16'h0, 16'h0, 24'h0),    E(RST, 16'h0, 16'h0, 24'h0, 4'd1, 0, 1, 0, 0));
    add(S_IDLE(),                              E(RST, 16'h0, 16'h0, 24'h0, 4'd1, 1, 0, 0, 0));
    add(S_CMD(ERR, 16'h0, 16'h0, 24'h0),       E(ERR, 16'h0, 16'h0, 24'h0, 4'd1, 0, 0, 0, 0));
    add(S_PAR(1, 0, 0, 24'h0),                 E(ERR, 16'h0, 16'h0, 24'h0, 4'd1, 1, 0, 0, 0));
    add(S_CMD(INI, 16'h1111, 16'h2222, 24'h0), E(ERR, 16'h0, 16'h0, 24'h0, 4'd1, 0, 1, 0, 0));
    add(S_IDLE(),                              E(ERR, 16'h0, 16'h0, 24'h0, 4'd1, 1, 0, 0, 0));
    add(S_CMD(RST, 16'h0, 16'h0, 24'h0),       E(RST, 16'h0, 16'h0, 24'h0, 4'd0, 0, 0, 0, 0));
    add(S_IDLE(),                              E(RST, 16'h0, 16'h0, 24'h0, 4'd0, 1, 0, 0, 0));
    // INIT->INIT relatch, PSN wrap, mismatch, threshold trip
    add(S_CMD(INI, 16'h00AA, 16'h00BB, 24'h0), E(INI, 16'h00AA, 16'h00BB, 24'h0, 4'd0, 0, 0, 0, 0));
    add(S_IDLE(),                              E(INI, 16'h00AA, 16'h00BB, 24'h0, 4'd0, 1, 0, 0, 0));
    add(S_CMD(INI, 16'h00CC, 16'h00DD, 24'h0), E(INI, 16'h00CC, 16'h00DD, 24'h0, 4'd0, 0, 0, 0, 0));
    add(S_IDLE(),                              E(INI, 16'h00CC, 16'h00DD, 24'h0, 4'd0, 1, 0, 0, 0));
    add(S_CMD(RTR, 16'h0, 16'h0, 24'hFFFFFF),  E(RTR, 16'h00CC, 16'h00DD, 24'hFFFFFF, 4'd0, 0, 0, 0, 0));
    add(S_IDLE(),                              E(RTR, 16'h00CC, 16'h00DD, 24'hFFFFFF, 4'd0, 1, 0, 0, 0));
    add(S_CMD(RTS, 16'h0, 16'h0, 24'h0),       E(RTS, 16'h00CC, 16'h00DD, 24'hFFFFFF, 4'd0, 0, 0, 0, 0));
    add(S_PAR(0, 0, 1, 24'hFFFFFF),            E(RTS, 16'h00CC, 16'h00DD, 24'h000000, 4'd0, 1, 0, 0, 0));
    add(S_PAR(0, 0, 1, 24'h000005),            E(RTS, 16'h00CC, 16'h00DD, 24'h000000, 4'd1, 1, 0, 1, 0));
    add(S_PAR(1, 0, 1, 24'h0),                 E(RTS, 16'h00CC, 16'h00DD, 24'h000000, 4'd2, 1, 0, 0, 0));
    add(S_PAR(1, 0, 1, 24'h0),                 E(RTS, 16'h00CC, 16'h00DD, 24'h000000, 4'd3, 1, 0, 0, 0));
    add(S_PAR(1, 0, 1, 24'h0),                 E(ERR, 16'h00CC, 16'h00DD, 24'h000000, 4'd4, 1, 0, 0, 1));
    add(S_IDLE(),                              E(ERR, 16'h00CC, 16'h00DD, 24'h000000, 4'd4, 1, 0, 0, 0));
    add(S_PAR(1, 0, 1, 24'h0),                 E(ERR, 16'h00CC, 16'h00DD, 24'h000000, 4'd4, 1, 0, 0, 0));
    add(S_CMD(RTS, 16'h0, 16'h0, 24'h0),       E(ERR, 16'h00CC, 16'h00DD, 24'h000000, 4'd4, 0, 1, 0, 0));
    add(S_IDLE(),                              E(ERR, 16'h00CC, 16'h00DD, 24'h000000, 4'd4, 1, 0, 0, 0));
    add(S_CMD(RST, 16'h0, 16'h0, 24'h0),       E(RST, 16'h0, 16'h0, 24'h0, 4'd0, 0, 0, 0, 0));
    add(S_IDLE(),                              E(RST, 16'h0, 16'h0, 24'h0, 4'd0, 1, 0, 0, 0));

    // ---------------- reset ----------------
    rst_n = 1'b0;
    drive(S_IDLE());
    repeat (2) @(posedge clk);
    #1;
    check(E(RST, 16'h0, 16'h0, 24'h0, 4'd0, 1, 0, 0, 0), "reset");
    rst_n = 1'b1;

    // ---------------- table ----------------
    for (int i = 0; i < table_q.size(); i++) begin
      step(table_q[i].s, table_q[i].e, $sformatf("vec%0d", i));
    end

    // ---------------- trip edge with RESET command ----------------
    to_rts(16'h0001, 16'h0002, 24'h000100, "t5a");
    step(S_PAR(1, 0, 1, 24'h0), E(RTS, 16'h1, 16'h2, 24'h100, 4'd1, 1, 0, 0, 0), "t5a err1");
    step(S_PAR(1, 0, 1, 24'h0), E(RTS, 16'h1, 16'h2, 24'h100, 4'd2, 1, 0, 0, 0), "t5a err2");
    step(S_PAR(1, 0, 1, 24'h0), E(RTS, 16'h1, 16'h2, 24'h100, 4'd3, 1, 0, 0, 0), "t5a err3");
    begin
      stim_t s;
      s = S_PAR(1, 0, 1, 24'h0);
      s.cv = 1'b1;
      s.cs = RST;
      step(s, E(RST, 16'h0, 16'h0, 24'h0, 4'd0, 0, 0, 0, 0), "t5a reset+trip");
    end
    step(S_IDLE(), E(RST, 16'h0, 16'h0, 24'h0, 4'd0, 1, 0, 0, 0), "t5a idle");

    // ---------------- trip edge with non-RESET command ----------------
    to_rts(16'h0001, 16'h0002, 24'h000100, "t5b");
    step(S_PAR(1, 0, 1, 24'h0), E(RTS, 16'h1, 16'h2, 24'h100, 4'd1, 1, 0, 0, 0), "t5b err1");
    step(S_PAR(1, 0, 1, 24'h0), E(RTS, 16'h1, 16'h2, 24'h100, 4'd2, 1, 0, 0, 0), "t5b err2");
    step(S_PAR(1, 0, 1, 24'h0), E(RTS, 16'h1, 16'h2, 24'h100, 4'd3, 1, 0, 0, 0), "t5b err3");
    begin
      stim_t s;
      s = S_PAR(1, 0, 1, 24'h0);
      s.cv = 1'b1;
      s.cs = RTR;
      s.ip = 24'h000777;
      step(s, E(ERR, 16'h1, 16'h2, 24'h100, 4'd4, 0, 1, 0, 1), "t5b rtr+trip");
    end
    step(S_IDLE(), E(ERR, 16'h1, 16'h2, 24'h100, 4'd4, 1, 0, 0, 0), "t5b idle");
    step(S_CMD(RST, 16'h0, 16'h0, 24'h0), E(RST, 16'h0, 16'h0, 24'h0, 4'd0, 0, 0, 0, 0), "t5b reset");
    step(S_IDLE(), E(RST, 16'h0, 16'h0, 24'h0, 4'd0, 1, 0, 0, 0), "t5b idle2");

    // ---------------- asynchronous reset mid-RTS ----------------
    to_rts(16'h0ABC, 16'h0DEF, 24'h000123, "t6");
    step(S_PAR(1, 0, 1, 24'h0),  E(RTS, 16'hABC, 16'hDEF, 24'h123, 4'd1, 1, 0, 0, 0), "t6 err1");
    step(S_PAR(0, 0, 1, 24'h7),  E(RTS, 16'hABC, 16'hDEF, 24'h123, 4'd2, 1, 0, 1, 0), "t6 psn mismatch");
    drive(S_IDLE());
    #2;
    rst_n = 1'b0;
    #1;
    check(E(RST, 16'h0, 16'h0, 24'h0, 4'd0, 1, 0, 0, 0), "t6 async reset");
    @(posedge clk);
    #1;
    check(E(RST, 16'h0, 16'h0, 24'h0, 4'd0, 1, 0, 0, 0), "t6 held in reset");
    rst_n = 1'b1;
    step(S_IDLE(), E(RST, 16'h0, 16'h0, 24'h0, 4'd0, 1, 0, 0, 0), "t6 after release");
    step(S_CMD(INI, 16'h0042, 16'h0043, 24'h0), E(INI, 16'h42, 16'h43, 24'h0, 4'd0, 0, 0, 0, 0), "t6 init again");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  // Safety net so a stuck run still terminates with a report.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, vectors=%0d", nvec);
    $fatal(1);
  end

endmodule
